// File: rtl/seq_signed_divider_pkg.sv
// rtl/seq_signed_divider_pkg.sv - shared types, widths and magnitude helpers for the signed divider
package div_pkg;

   localparam int DIV_WORD_LENGTH = 16;
   localparam int DIV_CNT_W       = $clog2(DIV_WORD_LENGTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DZ   = 2'd3
   } div_state_t;

   function automatic logic [DIV_WORD_LENGTH-1:0] neg_word(input logic [DIV_WORD_LENGTH-1:0] v);
      return ~v + DIV_WORD_LENGTH'(1);
   endfunction

   // The most-negative word maps to 2^(W-1), which still fits the unsigned result.
   function automatic logic [DIV_WORD_LENGTH-1:0] abs_mag(input logic signed [DIV_WORD_LENGTH-1:0] v);
      return v[DIV_WORD_LENGTH-1] ? neg_word(v) : v;
   endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// rtl/seq_signed_divider_if.sv - start/ready operand and result bundle for the signed divider
interface seq_signed_divider_if
   import div_pkg::*;
#(
   parameter int WORD_LENGTH = DIV_WORD_LENGTH
);
   logic                   start;
   logic [WORD_LENGTH-1:0] Data1;
   logic [WORD_LENGTH-1:0] Data2;
   logic [WORD_LENGTH-1:0] quotient;
   logic [WORD_LENGTH-1:0] remainder;
   logic                   ready;
   logic                   busy;
   logic                   div_by_zero;
   logic                   ovf;

   modport master (
      output start, Data1, Data2,
      input  quotient, remainder, ready, busy, div_by_zero, ovf
   );

   modport slave (
      input  start, Data1, Data2,
      output quotient, remainder, ready, busy, div_by_zero, ovf
   );
endinterface

// File: rtl/seq_signed_divider_restore_step.sv
// rtl/seq_signed_divider_restore_step.sv - one combinational radix-2 restoring division step
module div_restore_step
   import div_pkg::*;
#(
   parameter int WORD_LENGTH = DIV_WORD_LENGTH
)
(
   input  logic [WORD_LENGTH:0]   i_prem,
   input  logic                   i_dvd_msb,
   input  logic [WORD_LENGTH-1:0] i_dvs,
   output logic [WORD_LENGTH:0]   o_prem,
   output logic                   o_qbit
);
   // One extra guard bit so the trial difference sign is exact for a 2^(W-1) divisor.
   logic [WORD_LENGTH+1:0] w_shift;
   logic [WORD_LENGTH+1:0] w_diff;

   assign w_shift = {i_prem, i_dvd_msb};
   assign w_diff  = w_shift - {2'b00, i_dvs};
   assign o_qbit  = ~w_diff[WORD_LENGTH+1];
   assign o_prem  = o_qbit ? w_diff[WORD_LENGTH:0] : w_shift[WORD_LENGTH:0];
endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - sequential signed divider: magnitude restoring loop plus sign fix-up
module seq_signed_divider
   import div_pkg::*;
#(
   parameter int WORD_LENGTH = DIV_WORD_LENGTH
)
(
   input  logic                 clk,
   input  logic                 rst,
   seq_signed_divider_if.slave  bus
);
   localparam int                     CNT_W     = DIV_CNT_W;
   localparam logic [CNT_W-1:0]       LAST_STEP = CNT_W'(WORD_LENGTH - 1);
   localparam logic [WORD_LENGTH-1:0] MOST_NEG  = {1'b1, {(WORD_LENGTH-1){1'b0}}};

   div_state_t             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [WORD_LENGTH:0]   r_prem;
   logic [WORD_LENGTH-1:0] r_dvd;
   logic [WORD_LENGTH-1:0] r_dvs;
   logic                   r_neg_q;
   logic                   r_neg_r;
   logic                   r_ovf_case;
   logic [WORD_LENGTH-1:0] r_quot;
   logic [WORD_LENGTH-1:0] r_rem;
   logic                   r_ready;
   logic                   r_busy;
   logic                   r_dz;
   logic                   r_ovf;

   logic [WORD_LENGTH:0]   w_prem_next;
   logic                   w_qbit;
   logic [WORD_LENGTH-1:0] w_quot_fix;
   logic [WORD_LENGTH-1:0] w_rem_fix;
   logic [WORD_LENGTH-1:0] w_dvd_signed;

   div_restore_step #(.WORD_LENGTH(WORD_LENGTH)) u_step (
      .i_prem    (r_prem),
      .i_dvd_msb (r_dvd[WORD_LENGTH-1]),
      .i_dvs     (r_dvs),
      .o_prem    (w_prem_next),
      .o_qbit    (w_qbit)
   );

   // After the loop r_dvd holds the quotient magnitude; before it, the dividend magnitude.
   assign w_quot_fix   = r_neg_q ? neg_word(r_dvd) : r_dvd;
   assign w_rem_fix    = r_neg_r ? neg_word(r_prem[WORD_LENGTH-1:0]) : r_prem[WORD_LENGTH-1:0];
   assign w_dvd_signed = r_neg_r ? neg_word(r_dvd) : r_dvd;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_prem     <= '0;
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_ovf_case <= 1'b0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_dz       <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_neg_r    <= bus.Data1[WORD_LENGTH-1];
                  r_neg_q    <= bus.Data1[WORD_LENGTH-1] ^ bus.Data2[WORD_LENGTH-1];
                  r_dvd      <= abs_mag(bus.Data1);
                  r_dvs      <= abs_mag(bus.Data2);
                  r_prem     <= '0;
                  r_cnt      <= '0;
                  r_dz       <= 1'b0;
                  r_ovf      <= 1'b0;
                  r_ovf_case <= (bus.Data1 == MOST_NEG) && (bus.Data2 == '1);
                  r_busy     <= 1'b1;
                  r_state    <= (bus.Data2 == '0) ? DZ : ITER;
               end
            end
            ITER: begin
               r_prem <= w_prem_next;
               r_dvd  <= {r_dvd[WORD_LENGTH-2:0], w_qbit};
               r_cnt  <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_STEP) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_quot  <= w_quot_fix;
               r_rem   <= w_rem_fix;
               r_ovf   <= r_ovf_case;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            DZ: begin
               r_quot  <= '1;
               r_rem   <= w_dvd_signed;
               r_dz    <= 1'b1;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.ready       = r_ready;
   assign bus.busy        = r_busy;
   assign bus.div_by_zero = r_dz;
   assign bus.ovf         = r_ovf;
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - scoreboard bench for seq_signed_divider with directed vectors
module tb_seq_signed_divider;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ov;
      int          lat;
      int          e0;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_pass;
   int   spurious;
   exp_t sb[$];

   seq_signed_divider_if #(.WORD_LENGTH(16)) bus ();

   seq_signed_divider #(.WORD_LENGTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
   endtask

   always @(negedge clk) begin
      if (bus.ready === 1'b1) begin
         if (sb.size() == 0) begin
            spurious++;
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient",      bus.quotient,    e.q);
            check("remainder",     bus.remainder,   e.r);
            check("div_by_zero",   bus.div_by_zero, e.dz);
            check("ovf",           bus.ovf,         e.ov);
            check("latency",       cyc - e.e0,      e.lat);
            check("busy_at_ready", bus.busy,        1'b0);
         end
      end
   end

   task automatic issue(input logic [15:0] d1, input logic [15:0] d2, input logic push,
                        input logic [15:0] q, input logic [15:0] r,
                        input logic dz, input logic ov, input int lat);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.Data1 = d1;
      bus.Data2 = d2;
      if (push) begin
         e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat; e.e0 = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("ready_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic op(input logic [15:0] d1, input logic [15:0] d2,
                     input logic [15:0] q, input logic [15:0] r,
                     input logic dz, input logic ov, input int lat);
      issue(d1, d2, 1'b1, q, r, dz, ov, lat);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      spurious  = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.Data1 = 16'h0;
      bus.Data2 = 16'h0;
      repeat (3) @(negedge clk);
      check("rst_quotient",    bus.quotient,    16'h0);
      check("rst_remainder",   bus.remainder,   16'h0);
      check("rst_ready",       bus.ready,       1'b0);
      check("rst_busy",        bus.busy,        1'b0);
      check("rst_div_by_zero", bus.div_by_zero, 1'b0);
      check("rst_ovf",         bus.ovf,         1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      op(16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0, 17);
      op(16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17);
      op(16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17);
      op(16'hFFF9, 16'hFF9C, 16'h0000, 16'hFFF9, 1'b0, 1'b0, 17);
      op(16'd1234, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 1'b0, 1);
      op(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 17);
      op(16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 17);
      op(16'hFB2E, 16'h0000, 16'hFFFF, 16'hFB2E, 1'b1, 1'b0, 1);
      op(16'h0000, 16'd5,    16'h0000, 16'h0000, 1'b0, 1'b0, 17);
      op(16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 17);
      op(16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 17);
      op(16'h8000, 16'd7,    16'hEDB7, 16'hFFFF, 1'b0, 1'b0, 17);

      // A second start while busy must be ignored.
      issue(16'd100, 16'd7, 1'b1, 16'h000E, 16'h0002, 1'b0, 1'b0, 17);
      repeat (3) @(negedge clk);
      check("busy_mid_op", bus.busy, 1'b1);
      bus.start = 1'b1;
      bus.Data1 = 16'd50;
      bus.Data2 = 16'd5;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();

      // Reset mid-operation clears outputs at once and suppresses ready.
      issue(16'd100, 16'd7, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
      repeat (6) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_quotient",    bus.quotient,    16'h0);
      check("abort_remainder",   bus.remainder,   16'h0);
      check("abort_ready",       bus.ready,       1'b0);
      check("abort_busy",        bus.busy,        1'b0);
      check("abort_div_by_zero", bus.div_by_zero, 1'b0);
      check("abort_ovf",         bus.ovf,         1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (25) @(negedge clk);

      op(16'd9, 16'd3, 16'h0003, 16'h0000, 1'b0, 1'b0, 17);

      check("no_spurious_ready", spurious, 0);
      check("scoreboard_empty",  sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
